vram_bus_scheduler: RTL

VRAM_BUS_SCHEDULER -- requirements
Module: vram_bus_scheduler

---
 rtl/vram_bus_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vram_bus_scheduler.sv
// VRAM bus scheduler: time-multiplexes one 8K x 8 RAM between the video
// tile fetcher and two CPUs using a 4-phase slot wheel (V, M, V, S).
// Slots are decided on the edge that starts them and retired on the edge
// that ends them; nHSYNC falling edges realign the wheel to phase 0.
module vram_bus_scheduler #(
    parameter bit CPU_FALLBACK = 1'b1
) (
    input  logic        CLK_6M,
    input  logic        rst_n,
    input  logic        nHSYNC,
    input  logic [12:0] vid_addr,
    output logic [7:0]  vid_data,
    output logic        vid_valid,
    input  logic        m_req,
    input  logic        m_rnw,
    input  logic [12:0] m_addr,
    input  logic [7:0]  m_wdata,
    output logic        m_ack,
    output logic [7:0]  m_rdata,
    output logic        m_wait_n,
    input  logic        s_req,
    input  logic        s_rnw,
    input  logic [12:0] s_addr,
    input  logic [7:0]  s_wdata,
    output logic        s_ack,
    output logic [7:0]  s_rdata,
    output logic        s_wait_n,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    // Who owns the slot currently on the bus.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_M    = 2'd2,
        GNT_S    = 2'd3
    } gnt_e;

    logic [1:0]  phase_q,    phase_d;
    logic        nhs_q,      nhs_d;
    logic        resync_q,   resync_d;
    gnt_e        gnt_q,      gnt_d;
    logic        rnw_q,      rnw_d;
    logic [12:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        ram_ce_n_q, ram_ce_n_d;
    logic        ram_oe_n_q, ram_oe_n_d;
    logic        ram_we_n_q, ram_we_n_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic        vid_valid_q, vid_valid_d;
    logic        m_ack_q,    m_ack_d;
    logic [7:0]  m_rdata_q,  m_rdata_d;
    logic        s_ack_q,    s_ack_d;
    logic [7:0]  s_rdata_q,  s_rdata_d;

    // Next-slot arbitration, RAM strobe generation and retirement of the current slot.
    always_comb begin
        nhs_d    = nHSYNC;
        // Falling edge is flagged one cycle late; the flag then forces phase 0.
        resync_d = nhs_q & ~nHSYNC;
        phase_d  = resync_q ? 2'd0 : phase_q + 2'd1;

        // Even phases are video; phase 1 belongs to master, phase 3 to sub.
        gnt_d = GNT_NONE;
        if (!phase_d[0]) begin
            gnt_d = GNT_VID;
        end else if (!phase_d[1]) begin
            if (m_req)                      gnt_d = GNT_M;
            else if (CPU_FALLBACK && s_req) gnt_d = GNT_S;
        end else begin
            if (s_req)                      gnt_d = GNT_S;
            else if (CPU_FALLBACK && m_req) gnt_d = GNT_M;
        end

        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        ram_ce_n_d = 1'b1;
        ram_oe_n_d = 1'b1;
        ram_we_n_d = 1'b1;
        rnw_d      = 1'b1;
        case (gnt_d)
            GNT_VID: begin
                ram_addr_d = vid_addr;
                ram_ce_n_d = 1'b0;
                ram_oe_n_d = 1'b0;
            end
            GNT_M: begin
                ram_addr_d = m_addr;
                rnw_d      = m_rnw;
                ram_ce_n_d = 1'b0;
                ram_oe_n_d = ~m_rnw;
                ram_we_n_d = m_rnw;
                if (!m_rnw) ram_dout_d = m_wdata;
            end
            GNT_S: begin
                ram_addr_d = s_addr;
                rnw_d      = s_rnw;
                ram_ce_n_d = 1'b0;
                ram_oe_n_d = ~s_rnw;
                ram_we_n_d = s_rnw;
                if (!s_rnw) ram_dout_d = s_wdata;
            end
            default: ;
        endcase

        // Retire the slot that is on the bus right now; write data never updates rdata.
        vid_valid_d = (gnt_q == GNT_VID);
        vid_data_d  = (gnt_q == GNT_VID) ? ram_din : vid_data_q;
        m_ack_d     = (gnt_q == GNT_M);
        m_rdata_d   = (gnt_q == GNT_M && rnw_q) ? ram_din : m_rdata_q;
        s_ack_d     = (gnt_q == GNT_S);
        s_rdata_d   = (gnt_q == GNT_S && rnw_q) ? ram_din : s_rdata_q;
    end

    // State registers; reset drops any in-flight slot so no ack is produced.
    always_ff @(posedge CLK_6M) begin
        if (!rst_n) begin
            phase_q     <= 2'd0;
            nhs_q       <= 1'b1;
            resync_q    <= 1'b0;
            gnt_q       <= GNT_NONE;
            rnw_q       <= 1'b1;
            ram_addr_q  <= 13'd0;
            ram_dout_q  <= 8'd0;
            ram_ce_n_q  <= 1'b1;
            ram_oe_n_q  <= 1'b1;
            ram_we_n_q  <= 1'b1;
            vid_data_q  <= 8'd0;
            vid_valid_q <= 1'b0;
            m_ack_q     <= 1'b0;
            m_rdata_q   <= 8'd0;
            s_ack_q     <= 1'b0;
            s_rdata_q   <= 8'd0;
        end else begin
            phase_q     <= phase_d;
            nhs_q       <= nhs_d;
            resync_q    <= resync_d;
            gnt_q       <= gnt_d;
            rnw_q       <= rnw_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_ce_n_q  <= ram_ce_n_d;
            ram_oe_n_q  <= ram_oe_n_d;
            ram_we_n_q  <= ram_we_n_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            m_ack_q     <= m_ack_d;
            m_rdata_q   <= m_rdata_d;
            s_ack_q     <= s_ack_d;
            s_rdata_q   <= s_rdata_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_dout  = ram_dout_q;
    assign ram_ce_n  = ram_ce_n_q;
    assign ram_oe_n  = ram_oe_n_q;
    assign ram_we_n  = ram_we_n_q;
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign m_ack     = m_ack_q;
    assign m_rdata   = m_rdata_q;
    assign s_ack     = s_ack_q;
    assign s_rdata   = s_rdata_q;
    // A CPU is stretched while its request is outstanding and not yet acked.
    assign m_wait_n  = ~(m_req & ~m_ack_q);
    assign s_wait_n  = ~(s_req & ~s_ack_q);

endmodule
